// File: rtl/mul_div_pkg.sv
// -----------------------------------------------------------------------------
// mul_div_pkg
// Shared definitions for the multiply/divide unit: operation encodings, the
// sequencer state enumeration, the iteration count and small helpers.
// No ports (package).
// -----------------------------------------------------------------------------
package mul_div_pkg;

  localparam int DATA_W   = 32;  // operand / result width
  localparam int ITER_CNT = 32;  // radix-2 iterations per operation
  localparam int CNT_W    = 6;   // wide enough to hold ITER_CNT-1
  localparam int REG_W    = 5;   // register index width

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,  // low word of signed product
    OP_MULH = 2'b01,  // high word of signed product
    OP_DIV  = 2'b10,  // signed quotient
    OP_REM  = 2'b11   // signed remainder
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } state_e;

  // DIV and REM share the top encoding bit.
  function automatic logic is_div_op(input op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/mul_div_if.sv
// -----------------------------------------------------------------------------
// mul_div_if
// Request/write-back bundle between the issuing pipeline (master) and the
// multiply/divide unit (slave).
//
// Handshake: the master may raise start for one cycle whenever busy is low;
// a start seen while busy is high is ignored. The unit later raises wrReg for
// exactly one cycle; destReg, wrData and err are only meaningful in that
// cycle. There is no back-pressure on the write-back side.
//
//   start    m->s  request pulse
//   op       m->s  operation (see mul_div_pkg::op_e)
//   rs_val   m->s  operand A (signed)
//   rt_val   m->s  operand B (signed)
//   dest_in  m->s  destination register index
//   busy     s->m  unit occupied
//   wrReg    s->m  one-cycle write strobe
//   destReg  s->m  write index
//   wrData   s->m  result
//   err      s->m  divide-by-zero / unsupported operation flag
// -----------------------------------------------------------------------------
interface mul_div_if;

  logic                               start;
  logic [1:0]                         op;
  logic [mul_div_pkg::DATA_W-1:0]     rs_val;
  logic [mul_div_pkg::DATA_W-1:0]     rt_val;
  logic [mul_div_pkg::REG_W-1:0]      dest_in;
  logic                               busy;
  logic                               wrReg;
  logic [mul_div_pkg::REG_W-1:0]      destReg;
  logic [mul_div_pkg::DATA_W-1:0]     wrData;
  logic                               err;

  modport master (
    output start, op, rs_val, rt_val, dest_in,
    input  busy, wrReg, destReg, wrData, err
  );

  modport slave (
    input  start, op, rs_val, rt_val, dest_in,
    output busy, wrReg, destReg, wrData, err
  );

endinterface

// File: rtl/mul_div_signfix.sv
// -----------------------------------------------------------------------------
// mul_div_signfix
// Combinational conditional two's-complement negate. With neg_i tied to the
// operand's sign bit it yields the magnitude (abs of the most negative value
// comes out as the same bit pattern, which is the correct unsigned magnitude).
//   val_i  W-bit input value
//   neg_i  negate when high
//   val_o  W-bit result
// -----------------------------------------------------------------------------
module mul_div_signfix #(
  parameter int W = 32
) (
  input  logic [W-1:0] val_i,
  input  logic         neg_i,
  output logic [W-1:0] val_o
);

  assign val_o = neg_i ? ((~val_i) + {{(W-1){1'b0}}, 1'b1}) : val_i;

endmodule

// File: rtl/mul_div_unit.sv
// -----------------------------------------------------------------------------
// mul_div_unit
// Iterative signed multiply / divide unit. Operands are reduced to magnitudes
// on acceptance, processed by 32 radix-2 steps (shift-add or restoring
// shift-subtract), sign-corrected in one FIX cycle and written back with a
// one-cycle wrReg strobe.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   bus          mul_div_if.slave request / write-back bundle
//   dbg_state_o  current sequencer state (debug visibility)
//
// Build option: define MUL_DIV_DIVIDER_EN to include the divider datapath.
// Without it DIV/REM return 0 with err set after the short path.
// -----------------------------------------------------------------------------
module mul_div_unit
  import mul_div_pkg::*;
#(
  parameter int WIDTH = 32  // only 32 is supported
) (
  input  logic            clk,
  input  logic            rst_n,
  mul_div_if.slave        bus,
  output state_e          dbg_state_o
);

  state_e               state_q;
  op_e                  op_q;
  logic                 sa_q, sb_q;
  logic [WIDTH-1:0]     a_mag_q;
  logic [WIDTH-1:0]     hi_q, lo_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 busy_q, wrReg_q, err_q;
  logic [REG_W-1:0]     destReg_q;
  logic [WIDTH-1:0]     wrData_q;
`ifdef MUL_DIV_DIVIDER_EN
  logic [WIDTH-1:0]     b_mag_q;
`endif

  op_e                  op_in;
  logic [WIDTH-1:0]     abs_a, abs_b;
  logic                 short_path;
  logic [WIDTH-1:0]     short_data;
  logic [WIDTH-1:0]     addend;
  logic [WIDTH:0]       add_sum;
  logic [WIDTH-1:0]     hi_d, lo_d;
  logic [2*WIDTH-1:0]   fix_in, fix_out;
  logic                 fix_neg;
  logic [WIDTH-1:0]     fix_result;
`ifdef MUL_DIV_DIVIDER_EN
  logic [WIDTH:0]       shifted, trial;
`endif

  assign op_in = op_e'(bus.op);

  mul_div_signfix #(.W(WIDTH)) u_abs_a (
    .val_i (bus.rs_val),
    .neg_i (bus.rs_val[WIDTH-1]),
    .val_o (abs_a)
  );

  mul_div_signfix #(.W(WIDTH)) u_abs_b (
    .val_i (bus.rt_val),
    .neg_i (bus.rt_val[WIDTH-1]),
    .val_o (abs_b)
  );

  mul_div_signfix #(.W(2*WIDTH)) u_fix (
    .val_i (fix_in),
    .neg_i (fix_neg),
    .val_o (fix_out)
  );

  // Requests that complete without iterating: divide by zero, or any
  // divide-class op when the divider is not built in.
  always_comb begin
`ifdef MUL_DIV_DIVIDER_EN
    short_path = is_div_op(op_in) && (bus.rt_val == '0);
    short_data = (op_in == OP_DIV) ? '1 : bus.rs_val;
`else
    short_path = is_div_op(op_in);
    short_data = '0;
`endif
  end

  // One radix-2 step. Multiply: {hi,lo} holds partial product over the
  // shrinking multiplier. Divide: hi is the partial remainder, lo shifts the
  // dividend out and the quotient bits in.
  always_comb begin
    addend  = lo_q[0] ? a_mag_q : '0;
    add_sum = {1'b0, hi_q} + {1'b0, addend};
    hi_d    = add_sum[WIDTH:1];
    lo_d    = {add_sum[0], lo_q[WIDTH-1:1]};
`ifdef MUL_DIV_DIVIDER_EN
    // Partial remainder is always below the divisor (<= 2^31), so the
    // shifted value fits 32 bits and bit WIDTH of trial is a clean borrow.
    shifted = {hi_q, lo_q[WIDTH-1]};
    trial   = shifted - {1'b0, b_mag_q};
    if (is_div_op(op_q)) begin
      hi_d = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
      lo_d = {lo_q[WIDTH-2:0], ~trial[WIDTH]};
    end
`endif
  end

  // Sign correction: product and quotient take signA^signB, remainder takes
  // signA. The 64-bit negate covers the full product for MULH.
  always_comb begin
    fix_in  = {hi_q, lo_q};
    fix_neg = sa_q ^ sb_q;
`ifdef MUL_DIV_DIVIDER_EN
    if (op_q == OP_DIV) begin
      fix_in = {{WIDTH{1'b0}}, lo_q};
    end else if (op_q == OP_REM) begin
      fix_in  = {{WIDTH{1'b0}}, hi_q};
      fix_neg = sa_q;
    end
`endif
    fix_result = fix_out[WIDTH-1:0];
    if (op_q == OP_MULH) fix_result = fix_out[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_q      <= OP_MUL;
      sa_q      <= 1'b0;
      sb_q      <= 1'b0;
      a_mag_q   <= '0;
`ifdef MUL_DIV_DIVIDER_EN
      b_mag_q   <= '0;
`endif
      hi_q      <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      wrReg_q   <= 1'b0;
      err_q     <= 1'b0;
      destReg_q <= '0;
      wrData_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            op_q      <= op_in;
            sa_q      <= bus.rs_val[WIDTH-1];
            sb_q      <= bus.rt_val[WIDTH-1];
            a_mag_q   <= abs_a;
`ifdef MUL_DIV_DIVIDER_EN
            b_mag_q   <= abs_b;
`endif
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            destReg_q <= bus.dest_in;
            if (short_path) begin
              wrData_q <= short_data;
              state_q  <= DONE;
            end else begin
              hi_q    <= '0;
              lo_q    <= is_div_op(op_in) ? abs_a : abs_b;
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          hi_q  <= hi_d;
          lo_q  <= lo_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(ITER_CNT - 1)) state_q <= FIX;
        end
        FIX: begin
          wrData_q <= fix_result;
          wrReg_q  <= 1'b1;
          err_q    <= 1'b0;
          state_q  <= DONE;
        end
        DONE: begin
          // The normal path arrives with the strobe already raised. The short
          // path arrives with it low and raises it here (with err), giving a
          // one-cycle latency for error results.
          if (!wrReg_q) begin
            wrReg_q <= 1'b1;
            err_q   <= 1'b1;
          end else begin
            wrReg_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.wrReg   = wrReg_q;
  assign bus.err     = err_q;
  assign bus.destReg = destReg_q;
  assign bus.wrData  = wrData_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mul_div_unit
// Directed-vector bench for mul_div_unit. Expected results are hand-computed
// constants; the divide vectors follow the MUL_DIV_DIVIDER_EN build option.
// -----------------------------------------------------------------------------
module tb_mul_div_unit;
  import mul_div_pkg::*;

  logic   clk;
  logic   rst_n;
  state_e dbg_state;

  mul_div_if bus();

  mul_div_unit #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int n_vec = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Call just after a falling edge; returns just after a falling edge.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] dest,
                        input logic [31:0] exp_data, input logic exp_err, input int exp_lat);
    int k;
    logic [31:0] exp;
    exp_q.push_back(exp_data);
    bus.start = 1'b1; bus.op = op; bus.rs_val = a; bus.rt_val = b; bus.dest_in = dest;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    k = 0;
    check_eq({tag, "/busy"}, 32'(bus.busy), 32'd1);
    while (!bus.wrReg && k < 60) begin
      @(negedge clk);
      k++;
    end
    check_eq({tag, "/lat"}, 32'(k), 32'(exp_lat));
    exp = exp_q.pop_front();
    check_eq({tag, "/data"}, bus.wrData, exp);
    check_eq({tag, "/err"}, 32'(bus.err), 32'(exp_err));
    check_eq({tag, "/dest"}, 32'(bus.destReg), 32'(dest));
    @(negedge clk);
    check_eq({tag, "/wr_one_cycle"}, 32'(bus.wrReg), 32'd0);
    check_eq({tag, "/idle_busy"}, 32'(bus.busy), 32'd0);
    check_eq({tag, "/idle_err"}, 32'(bus.err), 32'd0);
  endtask

  task automatic count_wr(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.wrReg) pulses++;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k;
    int pulses;
    logic busy_seen;

    rst_n = 1'b0;
    bus.start = 1'b0; bus.op = 2'b00; bus.rs_val = '0; bus.rt_val = '0; bus.dest_in = '0;
    repeat (3) @(negedge clk);

    check_eq("rst/busy", 32'(bus.busy), 32'd0);
    check_eq("rst/wrReg", 32'(bus.wrReg), 32'd0);
    check_eq("rst/err", 32'(bus.err), 32'd0);
    check_eq("rst/destReg", 32'(bus.destReg), 32'd0);
    check_eq("rst/wrData", bus.wrData, 32'd0);
    check_eq("rst/state", 32'(dbg_state), 32'(IDLE));

    // Start accepted on the first edge after release.
    rst_n = 1'b1;
    run_op("mul_7x-6", OP_MUL, 32'd7, 32'hFFFFFFFA, 5'd5, 32'hFFFFFFD6, 1'b0, 33);
    run_op("mulh_big", OP_MULH, 32'h40000000, 32'd4, 5'd1, 32'h00000001, 1'b0, 33);
    run_op("mulh_-1x1", OP_MULH, 32'hFFFFFFFF, 32'd1, 5'd2, 32'hFFFFFFFF, 1'b0, 33);
    run_op("mul_-3x-5_d0", OP_MUL, 32'hFFFFFFFD, 32'hFFFFFFFB, 5'd0, 32'd15, 1'b0, 33);
    run_op("mul_min_sq", OP_MUL, 32'h80000000, 32'h80000000, 5'd7, 32'h00000000, 1'b0, 33);
    run_op("mulh_min_sq", OP_MULH, 32'h80000000, 32'h80000000, 5'd8, 32'h40000000, 1'b0, 33);
    run_op("mulh_min_x1", OP_MULH, 32'h80000000, 32'd1, 5'd9, 32'hFFFFFFFF, 1'b0, 33);

`ifdef MUL_DIV_DIVIDER_EN
    run_op("div_-7/2", OP_DIV, 32'hFFFFFFF9, 32'd2, 5'd3, 32'hFFFFFFFD, 1'b0, 33);
    run_op("rem_-7%2", OP_REM, 32'hFFFFFFF9, 32'd2, 5'd4, 32'hFFFFFFFF, 1'b0, 33);
    run_op("rem_7%-2", OP_REM, 32'd7, 32'hFFFFFFFE, 5'd6, 32'd1, 1'b0, 33);
    run_op("div_100/7", OP_DIV, 32'd100, 32'd7, 5'd10, 32'd14, 1'b0, 33);
    run_op("rem_-100%-7", OP_REM, 32'hFFFFFF9C, 32'hFFFFFFF9, 5'd11, 32'hFFFFFFFE, 1'b0, 33);
    run_op("div_5/0", OP_DIV, 32'd5, 32'd0, 5'd12, 32'hFFFFFFFF, 1'b1, 1);
    run_op("rem_5%0", OP_REM, 32'd5, 32'd0, 5'd13, 32'd5, 1'b1, 1);
    run_op("div_min/-1", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'h80000000, 1'b0, 33);
    run_op("rem_min/-1", OP_REM, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'd0, 1'b0, 33);
`else
    run_op("div_6/3_off", OP_DIV, 32'd6, 32'd3, 5'd3, 32'd0, 1'b1, 1);
    run_op("rem_6%3_off", OP_REM, 32'd6, 32'd3, 5'd4, 32'd0, 1'b1, 1);
    run_op("div_5/0_off", OP_DIV, 32'd5, 32'd0, 5'd12, 32'd0, 1'b1, 1);
`endif

    // Second start while busy must be ignored.
    bus.start = 1'b1; bus.op = OP_MUL; bus.rs_val = 32'd3; bus.rt_val = 32'd4; bus.dest_in = 5'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    k = 0;
    busy_seen = 1'b1;
    while (!bus.wrReg && k < 60) begin
      @(negedge clk);
      if (k == 4) begin
        bus.start = 1'b1; bus.op = OP_DIV; bus.rs_val = 32'd100; bus.rt_val = 32'd0; bus.dest_in = 5'd9;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        k++;
        busy_seen = bus.busy;
      end
      if (!bus.wrReg) k++;
    end
    check_eq("ignore/busy_held", 32'(busy_seen), 32'd1);
    check_eq("ignore/lat", 32'(k), 32'd33);
    check_eq("ignore/data", bus.wrData, 32'd12);
    check_eq("ignore/dest", 32'(bus.destReg), 32'd3);
    check_eq("ignore/err", 32'(bus.err), 32'd0);
    count_wr(40, pulses);
    check_eq("ignore/single_result", 32'(pulses), 32'd0);

    // Reset mid-operation aborts without any write-back.
    bus.start = 1'b1; bus.op = OP_MULH; bus.rs_val = 32'd9; bus.rt_val = 32'd9; bus.dest_in = 5'd20;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("abort/busy", 32'(bus.busy), 32'd0);
    check_eq("abort/state", 32'(dbg_state), 32'(IDLE));
    count_wr(5, pulses);
    rst_n = 1'b1;
    count_wr(35, k);
    check_eq("abort/no_wr", 32'(pulses + k), 32'd0);

    // Unit is usable again straight after an abort.
    run_op("post_abort_mul", OP_MUL, 32'd123, 32'd456, 5'd31, 32'd56088, 1'b0, 33);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request pulse; sampled only in IDLE.
REQ-005 SHALL have port op  input  2  operation: 00 MUL (low word), 01 MULH (signed high word), 10 DIV (signed quotient), 11 REM (signed remainder).
REQ-006 SHALL have port rs_val  input  32  signed operand A, taken from register-bank read port 1.
REQ-007 SHALL have port rt_val  input  32  signed operand B, taken from register-bank read port 2.
REQ-008 SHALL have port dest_in  input  5  destination register index.
REQ-009 SHALL have port busy  output  1  high in every state except IDLE.
REQ-010 SHALL have port wrReg  output  1  one-cycle register-bank write strobe.
REQ-011 SHALL have port destReg  output  5  write index, valid while wrReg is high.
REQ-012 SHALL have port wrData  output  32  result, valid while wrReg is high.
REQ-013 SHALL have port err  output  1  one-cycle flag, coincident with wrReg, marking a divide-by-zero or a disabled operation.

Function
REQ-014 SHALL implement states IDLE, CALC, FIX and DONE.
REQ-015 SHALL, on the rising edge where state is IDLE and start=1: latch op, dest_in, and the magnitudes and signs of both operands; clear the iteration counter; go to CALC.
REQ-016 SHALL, in CALC, perform one radix-2 iteration per cycle (shift-add for MUL/MULH, restoring shift-subtract for DIV/REM) for exactly 32 cycles, then go to FIX.
REQ-017 SHALL, in FIX, apply sign correction in one cycle: product sign = signA xor signB; quotient sign = signA xor signB; remainder sign = signA. Then go to DONE.
REQ-018 SHALL, in DONE, drive wrReg=1 with destReg and wrData registered, then return to IDLE on the next edge.
REQ-019 SHALL give wrReg first high in the cycle following edge N+33 when start is sampled at edge N (latency 33).
REQ-020 SHALL, for DIV/REM with rt_val=0, go from IDLE directly to DONE (wrReg visible after edge N+1) with err=1: DIV gives 0xFFFFFFFF, REM gives rs_val.
REQ-021 SHALL give DIV 0x80000000 / -1 = 0x80000000 and REM = 0, with err=0, via the normal path.
REQ-022 SHALL ignore start while busy=1; the in-flight operation and its latched operands SHALL be unaffected.
REQ-023 SHALL pulse wrReg even when dest_in=0; discarding the write is the register bank's responsibility.
REQ-024 SHALL hold wrReg, err and busy low in IDLE.
REQ-025 SHALL be fully accounted for by REQ-017 sign handling for all operand sign combinations.

Reset
REQ-026 SHALL, on rst_n low, asynchronously force state IDLE, busy=0, wrReg=0, err=0, destReg=0, wrData=0, counter=0, and clear all operand and accumulator registers.
REQ-027 SHALL, on reset asserted mid-operation, abort with no wrReg pulse, ever, for the aborted request.
REQ-028 SHALL accept a new start on the first edge after rst_n deasserts.

Configuration
REQ-029 SHALL, with macro MUL_DIV_DIVIDER_EN defined, implement DIV/REM as specified above.
REQ-030 SHALL, without MUL_DIV_DIVIDER_EN, contain no divider datapath; DIV/REM SHALL go IDLE to DONE and return wrData=0 with err=1; MUL/MULH SHALL be unchanged.

Structure
REQ-031 SHALL take the op encodings (OP_MUL, OP_MULH, OP_DIV, OP_REM), the state enumeration, and the ITER_CNT=32 constant from shared package mul_div_pkg.
REQ-032 SHALL use one sub-module, mul_div_signfix: combinational absolute value and conditional negate, used for input magnitudes and FIX correction.

Verification
REQ-033 SHALL verify: MUL 7 x -6, dest 5 -> wrReg exactly one cycle, 33 cycles after start, wrData=0xFFFFFFD6, destReg=5, err=0.
REQ-034 SHALL verify: MULH 0x40000000 x 4 -> wrData=0x00000001; MULH -1 x 1 -> wrData=0xFFFFFFFF.
REQ-035 SHALL verify: DIV -7 / 2 -> 0xFFFFFFFD (-3); REM -7 % 2 -> 0xFFFFFFFF (-1); REM 7 % -2 -> 1.
REQ-036 SHALL verify: DIV 5 / 0 -> err=1, wrData=0xFFFFFFFF one cycle after start; REM 5 % 0 -> 5; without the macro, DIV 6 / 3 -> wrData=0, err=1.
REQ-037 SHALL verify: DIV 0x80000000 / -1 -> 0x80000000; REM -> 0; err=0 for both.
REQ-038 SHALL verify: start MUL, then a second start at cycle 5 -> ignored, single result; rst_n low at cycle 10 -> busy=0 immediately, no wrReg through cycle 50.
